// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives the ROM address and
// buffers {pc, inst} pairs in a small skid FIFO presented over valid/ready.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        halted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [31:0]      fetch_pc;
  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];

  logic        deq;
  logic        enq;
  logic        full;
  logic [31:0] redirect_target;

  // Masking keeps every redirect_pc bit in the expression; the low two are
  // architecturally ignored because fetch is always word aligned.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign deq       = out_valid & out_ready;

  // A full buffer may still accept a fetch when the head leaves this cycle,
  // which is what sustains one instruction per cycle with depth 2.
  assign enq = (state == ST_RUN) & ~halt_req & ~redirect_valid & (~full | deq);

  assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;
  assign halted   = (state == ST_HALTED) & ~out_valid;

  // Control state: PC, FSM, pointers and occupancy.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
      state    <= ST_RUN;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over everything: flush, retarget and leave HALTED.
      fetch_pc <= redirect_target;
      state    <= ST_RUN;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (enq) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      case (state)
        ST_RUN:    if (halt_req)  state <= ST_HALTED;
        ST_HALTED: if (!halt_req) state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // Buffer payload. Entries are only observed through count, so they carry
  // no reset.
  // NOTE: storage arrays are deliberately left out of the reset domain; the
  // valid bookkeeping (count/pointers) is what must reset, and an unreset
  // array maps to plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= imem_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed + randomized bench for inst_fetch_ctrl against a queue-based model
// of the fetch buffer, with a 32-word combinational ROM.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        halted;

  logic [31:0] rom [32];
  logic [4:0]  rom_idx;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of {pc, inst} plus the fetch PC and run flag.
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  bit          m_run;

  always #5 clk = ~clk;

  assign rom_idx   = 5'((imem_addr & 32'h0000_007C) >> 2);
  assign imem_inst = rom[rom_idx];

  inst_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] a;
    a = addr >> 2;
    return rom[a[4:0]];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc  = RESET_PC;
    m_run = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_pc, e_inst;
    e_pc   = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
    e_inst = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
    check({tag, ".valid"},  32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".pc"},     out_pc,         e_pc);
    check({tag, ".inst"},   out_inst,       e_inst);
    check({tag, ".addr"},   imem_addr,      m_pc);
    check({tag, ".halted"}, 32'(halted),    32'(!m_run && mq.size() == 0));
  endtask

  // Drive one cycle's inputs (aligned at negedge), check, advance model.
  task automatic step(input string tag, input bit rv, input logic [31:0] rpc,
                      input bit hr, input bit rdy);
    bit do_deq, do_enq;
    int sz;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    out_ready      = rdy;
    #1;
    check_all(tag);
    sz     = mq.size();
    do_deq = (sz != 0) && rdy;
    if (rv) begin
      mq.delete();
      m_pc  = rpc & 32'hFFFF_FFFC;
      m_run = 1'b1;
    end else begin
      do_enq = m_run && !hr && (sz < DEPTH || do_deq);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        mq.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (m_run && hr)        m_run = 1'b0;
      else if (!m_run && !hr) m_run = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0A00_0000 + 32'(i) * 32'h0001_0101;
    rom[0]  = 32'h8C01_0003;
    rom[1]  = 32'h8C02_0004;
    rom[16] = 32'h1022_1234;
    rom[31] = 32'hDEAD_BEEF;

    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;
    rst_n          = 1'b0;
    @(negedge clk);
    do_reset();

    // Streaming from reset with the consumer always ready.
    step("t1", 0, 0, 0, 1);
    check("t1_inst0", out_inst, 32'h8C01_0003);
    step("t1", 0, 0, 0, 1);
    check("t1_inst1", out_inst, 32'h8C02_0004);
    check("t1_pc1",   out_pc,   32'h4);
    repeat (4) step("t1", 0, 0, 0, 1);

    // Backpressure: buffer fills, fetch stalls at 8, head holds.
    do_reset();
    repeat (4) step("t2_stall", 0, 0, 0, 0);
    check("t2_addr", imem_addr, 32'h8);
    check("t2_head", out_pc,    32'h0);
    repeat (4) step("t2_drain", 0, 0, 0, 1);

    // Redirect while full.
    repeat (3) step("t3_fill", 0, 0, 0, 0);
    step("t3_redir", 1, 32'h43, 0, 0);
    check("t3_bubble", 32'(out_valid), 32'h0);
    check("t3_addr",   imem_addr,      32'h40);
    step("t3", 0, 0, 0, 0);
    check("t3_pc",   out_pc,   32'h40);
    check("t3_inst", out_inst, 32'h1022_1234);

    // Halt with two entries queued, drain, then resume.
    step("t4_fill", 0, 0, 0, 0);
    repeat (4) step("t4_halt", 0, 0, 1, 1);
    check("t4_halted", 32'(halted), 32'h1);
    repeat (3) step("t4_resume", 0, 0, 0, 1);

    // Back-to-back redirects: last one wins.
    step("bb1", 1, 32'h100, 0, 1);
    step("bb2", 1, 32'h206, 0, 1);
    check("bb_addr", imem_addr, 32'h204);
    repeat (3) step("bb", 0, 0, 0, 1);

    // PC wrap at the top of the address space.
    step("t5_redir", 1, 32'hFFFF_FFFC, 0, 1);
    step("t5", 0, 0, 0, 1);
    check("t5_pc_top",   out_pc,   32'hFFFF_FFFC);
    check("t5_inst_top", out_inst, 32'hDEAD_BEEF);
    step("t5", 0, 0, 0, 1);
    check("t5_pc_wrap",   out_pc,   32'h0);
    check("t5_inst_wrap", out_inst, 32'h8C01_0003);

    // Asynchronous reset mid-stream (count is 1 in steady streaming).
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'h0);
    model_reset();
    check_all("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    step("t6", 0, 0, 0, 1);
    check("t6_restart", out_pc, RESET_PC);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit          rv, hr, rdy;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      hr  = (n % 40 > 30) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step("rand", rv, rpc, hr, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
